// File: rtl/axi_packet_gate_pkg.sv
// Shared types and helpers for the store-and-forward AXI-Stream packet gate.
package axi_packet_gate_pkg;

  typedef enum logic {
    ST_ACCEPT = 1'b0,
    ST_DROP   = 1'b1
  } gate_state_t;

  localparam int unsigned STAT_W = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/axi_packet_gate_ram.sv
// Simple dual-port buffer RAM: one write port, registered read port.
// Only the read register is reset; the array itself is not.
module axi_packet_gate_ram #(
  parameter int unsigned DATA_W = 33,
  parameter int unsigned SIZE   = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              we,
  input  logic [SIZE-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [SIZE-1:0]   raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**SIZE];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  rdata <= '0;
    else if (clear) rdata <= '0;
    else if (re)   rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_packet_gate_mp.sv
// Store-and-forward AXI-Stream packet gate with a cap on committed packets held.
// Define AXI_PACKET_GATE_STATS_EN to build the saturating drop counters.
module axi_packet_gate_mp
  import axi_packet_gate_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SIZE     = 6,
  parameter int unsigned MAX_PKTS = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           clear,
  input  logic [WIDTH-1:0]               i_tdata,
  input  logic                           i_tvalid,
  input  logic                           i_tlast,
  input  logic                           i_terror,
  output logic                           i_tready,
  output logic [WIDTH-1:0]               o_tdata,
  output logic                           o_tvalid,
  output logic                           o_tlast,
  input  logic                           o_tready,
  output logic [$clog2(MAX_PKTS+1)-1:0]  o_pkts_held,
  output logic [STAT_W-1:0]              o_err_drops,
  output logic [STAT_W-1:0]              o_ovf_drops
);

  localparam int unsigned   CW       = $clog2(MAX_PKTS+1);
  localparam logic [SIZE:0] PTR_ONE  = (SIZE+1)'(1);
  localparam logic [SIZE:0] PTR_FULL = {1'b1, {SIZE{1'b0}}};
  localparam logic [CW-1:0] PKT_CAP  = CW'(MAX_PKTS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  gate_state_t   state;
  logic [SIZE:0] wr_ptr, commit_ptr, rd_ptr, rd_next;
  logic          err_acc, ready_en;
  logic          full, cap_ok, ovf, wr_en, pkt_err, commit;
  logic          drain, pkt_drain, load;
  logic [WIDTH:0] rdata;

  always_comb begin
    full      = (wr_ptr - rd_ptr) == PTR_FULL;
    cap_ok    = o_pkts_held < PKT_CAP;
    ovf       = (state == ST_ACCEPT) && full && (commit_ptr == rd_ptr);
    i_tready  = ready_en && ((state == ST_DROP) || (!full && cap_ok));
    wr_en     = (state == ST_ACCEPT) && i_tvalid && i_tready;
    pkt_err   = err_acc | i_terror;
    commit    = wr_en && i_tlast && !pkt_err;
    drain     = o_tvalid && o_tready;
    pkt_drain = drain && o_tlast;
    rd_next   = drain ? rd_ptr + PTR_ONE : rd_ptr;
    // The RAM read register is the output stage: it is re-addressed with the
    // post-handshake pointer so a new word lands the same edge the old one leaves.
    load      = rd_next != commit_ptr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_ACCEPT;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      err_acc    <= 1'b0;
    end else if (clear) begin
      state      <= ST_ACCEPT;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      err_acc    <= 1'b0;
    end else begin
      unique case (state)
        ST_ACCEPT: begin
          if (ovf) begin
            state   <= ST_DROP;
            wr_ptr  <= commit_ptr;
            err_acc <= 1'b0;
          end else if (wr_en) begin
            if (!i_tlast) begin
              wr_ptr  <= wr_ptr + PTR_ONE;
              err_acc <= pkt_err;
            end else begin
              err_acc <= 1'b0;
              if (pkt_err) begin
                wr_ptr <= commit_ptr;
              end else begin
                wr_ptr     <= wr_ptr + PTR_ONE;
                commit_ptr <= wr_ptr + PTR_ONE;
              end
            end
          end
        end
        ST_DROP: begin
          if (i_tvalid && i_tready && i_tlast) begin
            state   <= ST_ACCEPT;
            err_acc <= 1'b0;
          end
        end
        default: state <= ST_ACCEPT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr      <= '0;
      o_tvalid    <= 1'b0;
      o_pkts_held <= '0;
    end else if (clear) begin
      rd_ptr      <= '0;
      o_tvalid    <= 1'b0;
      o_pkts_held <= '0;
    end else begin
      rd_ptr   <= rd_next;
      o_tvalid <= load;
      unique case ({commit, pkt_drain})
        2'b10:   o_pkts_held <= o_pkts_held + CNT_ONE;
        2'b01:   o_pkts_held <= o_pkts_held - CNT_ONE;
        default: o_pkts_held <= o_pkts_held;
      endcase
    end
  end

  axi_packet_gate_ram #(
    .DATA_W (WIDTH + 1),
    .SIZE   (SIZE)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .we      (wr_en),
    .waddr   (wr_ptr[SIZE-1:0]),
    .wdata   ({i_tlast, i_tdata}),
    .re      (load),
    .raddr   (rd_next[SIZE-1:0]),
    .rdata   (rdata)
  );

  assign o_tdata = rdata[WIDTH-1:0];
  assign o_tlast = rdata[WIDTH];

`ifdef AXI_PACKET_GATE_STATS_EN
  logic [STAT_W-1:0] err_cnt, ovf_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt <= '0;
      ovf_cnt <= '0;
    end else if (clear) begin
      err_cnt <= '0;
      ovf_cnt <= '0;
    end else begin
      if (wr_en && i_tlast && pkt_err) err_cnt <= sat_inc(err_cnt);
      if (ovf)                         ovf_cnt <= sat_inc(ovf_cnt);
    end
  end

  assign o_err_drops = err_cnt;
  assign o_ovf_drops = ovf_cnt;
`else
  assign o_err_drops = '0;
  assign o_ovf_drops = '0;
`endif

endmodule

// File: tb/tb_axi_packet_gate_mp.sv
// Directed self-checking bench for axi_packet_gate_mp (default parameters).
module tb_axi_packet_gate_mp;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned SIZE     = 6;
  localparam int unsigned MAX_PKTS = 8;
  localparam int unsigned CW       = $clog2(MAX_PKTS+1);
`ifdef AXI_PACKET_GATE_STATS_EN
  localparam int unsigned STATS = 1;
`else
  localparam int unsigned STATS = 0;
`endif

  logic             clk, reset_n, clear;
  logic [WIDTH-1:0] i_tdata, o_tdata;
  logic             i_tvalid, i_tlast, i_terror, i_tready;
  logic             o_tvalid, o_tlast, o_tready;
  logic [CW-1:0]    o_pkts_held;
  logic [15:0]      o_err_drops, o_ovf_drops;

  axi_packet_gate_mp #(
    .WIDTH    (WIDTH),
    .SIZE     (SIZE),
    .MAX_PKTS (MAX_PKTS)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (clear),
    .i_tdata     (i_tdata),
    .i_tvalid    (i_tvalid),
    .i_tlast     (i_tlast),
    .i_terror    (i_terror),
    .i_tready    (i_tready),
    .o_tdata     (o_tdata),
    .o_tvalid    (o_tvalid),
    .o_tlast     (o_tlast),
    .o_tready    (o_tready),
    .o_pkts_held (o_pkts_held),
    .o_err_drops (o_err_drops),
    .o_ovf_drops (o_ovf_drops)
  );

  int errors = 0;
  int checks = 0;
  int ready_mode = 0;
  int cyc = 0;
  int stall_cnt = 0;

  logic [WIDTH-1:0] got_d[$];
  logic             got_l[$];
  int               got_c[$];
  logic [WIDTH-1:0] exp_d[$];
  logic             exp_l[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output-side ready: 0 = held low, 1 = held high, 2 = random stalls.
  initial begin
    o_tready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       o_tready = 1'b0;
        1:       o_tready = 1'b1;
        default: o_tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    if (reset_n && !clear && o_tvalid && o_tready) begin
      got_d.push_back(o_tdata);
      got_l.push_back(o_tlast);
      got_c.push_back(cyc);
    end
  end

  initial begin
    #600000;
    errors++;
    checks++;
    $display("FAIL watchdog: time limit reached, required completion earlier");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic abort_run(input string what);
    errors++;
    checks++;
    $display("FAIL %s: no progress within cycle budget", what);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "budget expired");
  endtask

  task automatic clear_q();
    got_d.delete(); got_l.delete(); got_c.delete();
    exp_d.delete(); exp_l.delete();
  endtask

  task automatic idle_in();
    i_tvalid = 1'b0; i_tlast = 1'b0; i_terror = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send_beat(input logic [WIDTH-1:0] d, input logic l, input logic e);
    int n = 0;
    bit hs = 0;
    i_tvalid = 1'b1; i_tdata = d; i_tlast = l; i_terror = e;
    while (!hs) begin
      hs = i_tready;
      @(posedge clk);
      if (!hs) begin
        n++;
        stall_cnt++;
        if (n > 3000) abort_run("send_beat");
        @(negedge clk);
      end
    end
    @(negedge clk);
  endtask

  task automatic send_pkt(input logic [WIDTH-1:0] base, input int len, input int err_beat);
    for (int i = 0; i < len; i++)
      send_beat(base + WIDTH'(i), i == len - 1, i == err_beat);
    idle_in();
  endtask

  task automatic add_exp(input logic [WIDTH-1:0] base, input int len);
    for (int i = 0; i < len; i++) begin
      exp_d.push_back(base + WIDTH'(i));
      exp_l.push_back(i == len - 1);
    end
  endtask

  task automatic wait_out(input int n, input string what);
    int t = 0;
    while (got_d.size() < n) begin
      @(negedge clk);
      t++;
      if (t > 5000) abort_run(what);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    idle_in();
    clear = 1'b0;
    ready_mode = 0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    clear_q();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", o_tvalid); end
    checks++; if (o_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b want 0", o_tlast); end
    checks++; if (o_tdata !== '0) begin errors++; $display("FAIL rst_tdata: got %h want 0", o_tdata); end
    checks++; if (o_pkts_held !== '0) begin errors++; $display("FAIL rst_pkts: got %0d want 0", o_pkts_held); end
    checks++; if (o_err_drops !== 16'd0) begin errors++; $display("FAIL rst_err: got %0d want 0", o_err_drops); end
    checks++; if (o_ovf_drops !== 16'd0) begin errors++; $display("FAIL rst_ovf: got %0d want 0", o_ovf_drops); end
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (i_tready !== 1'b1) begin errors++; $display("FAIL rst_tready: got %b want 1", i_tready); end
    checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid_after: got %b want 0", o_tvalid); end
  endtask

  task automatic test_fill_drain();
    bit early = 0;
    do_reset();
    ready_mode = 1;
    for (int i = 0; i < 64; i++) begin
      send_beat(32'hA000_0000 + 32'(i), i == 63, 1'b0);
      if (o_tvalid) early = 1;
    end
    idle_in();
    add_exp(32'hA000_0000, 64);
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL fill_early_valid: got %b want 0", early); end
    @(negedge clk);
    checks++; if (o_tvalid !== 1'b1) begin errors++; $display("FAIL fill_latency: got %b want 1", o_tvalid); end
    checks++; if (o_tdata !== 32'hA000_0000) begin errors++; $display("FAIL fill_first: got %h want a0000000", o_tdata); end
    wait_out(64, "fill_drain");
    checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL fill_count: got %0d want %0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL fill_word[%0d]: got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_error_drop();
    do_reset();
    ready_mode = 1;
    send_pkt(32'hE000_0000, 16, -1);
    send_pkt(32'hE000_0010, 16, 5);
    send_pkt(32'hE000_0020, 16, -1);
    add_exp(32'hE000_0000, 16);
    add_exp(32'hE000_0020, 16);
    wait_out(32, "error_drop");
    checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL err_count: got %0d want %0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL err_word[%0d]: got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    checks++; if (o_err_drops !== 16'(STATS)) begin errors++; $display("FAIL err_drops: got %0d want %0d", o_err_drops, STATS); end
    checks++; if (o_ovf_drops !== 16'd0) begin errors++; $display("FAIL err_ovf: got %0d want 0", o_ovf_drops); end
    checks++; if (o_pkts_held !== '0) begin errors++; $display("FAIL err_pkts: got %0d want 0", o_pkts_held); end
  endtask

  task automatic test_oversize();
    do_reset();
    ready_mode = 1;
    send_pkt(32'hB000_0000, 80, -1);
    send_pkt(32'hBB00_0000, 10, -1);
    add_exp(32'hBB00_0000, 10);
    wait_out(10, "oversize");
    checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL ovf_count: got %0d want %0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL ovf_word[%0d]: got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    checks++; if (o_ovf_drops !== 16'(STATS)) begin errors++; $display("FAIL ovf_drops: got %0d want %0d", o_ovf_drops, STATS); end
    checks++; if (o_err_drops !== 16'd0) begin errors++; $display("FAIL ovf_err: got %0d want 0", o_err_drops); end
  endtask

  task automatic test_pkt_cap();
    logic [WIDTH-1:0] held;
    do_reset();
    ready_mode = 0;
    for (int p = 0; p < 8; p++) begin
      send_pkt(32'hC000_0000 + 32'(p * 4), 4, -1);
      add_exp(32'hC000_0000 + 32'(p * 4), 4);
    end
    checks++; if (o_pkts_held !== CW'(8)) begin errors++; $display("FAIL cap_held: got %0d want 8", o_pkts_held); end
    checks++; if (o_tvalid !== 1'b1) begin errors++; $display("FAIL cap_valid: got %b want 1", o_tvalid); end
    held = o_tdata;
    repeat (3) @(negedge clk);
    checks++; if (o_tdata !== 32'hC000_0000 || held !== 32'hC000_0000) begin
      errors++; $display("FAIL cap_hold: got %h then %h want c0000000", held, o_tdata);
    end
    i_tvalid = 1'b1; i_tdata = 32'hC000_0020; i_tlast = 1'b0; i_terror = 1'b0;
    checks++; if (i_tready !== 1'b0) begin errors++; $display("FAIL cap_tready: got %b want 0", i_tready); end
    ready_mode = 1;
    send_pkt(32'hC000_0020, 4, -1);
    add_exp(32'hC000_0020, 4);
    wait_out(36, "pkt_cap");
    checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL cap_count: got %0d want %0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL cap_word[%0d]: got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    checks++; if (o_pkts_held !== '0) begin errors++; $display("FAIL cap_held_end: got %0d want 0", o_pkts_held); end
  endtask

  task automatic test_back_to_back();
    int lens [3] = '{8, 1, 5};
    int k = 0;
    do_reset();
    ready_mode = 1;
    stall_cnt = 0;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < lens[p]; i++) begin
        send_beat(32'hD000_0000 + 32'(k), i == lens[p] - 1, 1'b0);
        exp_d.push_back(32'hD000_0000 + 32'(k));
        exp_l.push_back(i == lens[p] - 1);
        k++;
      end
    end
    idle_in();
    checks++; if (stall_cnt !== 0) begin errors++; $display("FAIL b2b_in_stall: got %0d want 0", stall_cnt); end
    wait_out(14, "back_to_back");
    checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL b2b_count: got %0d want %0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL b2b_word[%0d]: got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    if (got_c.size() >= 14) begin
      checks++;
      if (got_c[13] - got_c[0] !== 13) begin
        errors++; $display("FAIL b2b_bubble: got span %0d want 13", got_c[13] - got_c[0]);
      end
    end
  endtask

  task automatic test_clear_reset();
    do_reset();
    ready_mode = 0;
    send_pkt(32'h1000_0000, 4, -1);
    for (int i = 0; i < 4; i++) send_beat(32'h1100_0000 + 32'(i), 1'b0, 1'b0);
    idle_in();
    checks++; if (o_pkts_held !== CW'(1)) begin errors++; $display("FAIL clr_held_before: got %0d want 1", o_pkts_held); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL clr_tvalid: got %b want 0", o_tvalid); end
    checks++; if (o_pkts_held !== '0) begin errors++; $display("FAIL clr_held: got %0d want 0", o_pkts_held); end
    ready_mode = 1;
    clear_q();
    send_pkt(32'h2000_0000, 8, -1);
    add_exp(32'h2000_0000, 8);
    wait_out(8, "clear_new_pkt");
    checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL clr_count: got %0d want %0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL clr_word[%0d]: got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end

    ready_mode = 0;
    repeat (2) @(negedge clk);
    send_pkt(32'h3000_0000, 4, -1);
    @(negedge clk);
    checks++; if (o_tvalid !== 1'b1) begin errors++; $display("FAIL mrst_pre_valid: got %b want 1", o_tvalid); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL mrst_tvalid: got %b want 0", o_tvalid); end
    checks++; if (o_tdata !== '0) begin errors++; $display("FAIL mrst_tdata: got %h want 0", o_tdata); end
    checks++; if (o_pkts_held !== '0) begin errors++; $display("FAIL mrst_held: got %0d want 0", o_pkts_held); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (i_tready !== 1'b1) begin errors++; $display("FAIL mrst_tready: got %b want 1", i_tready); end
    checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL mrst_after_valid: got %b want 0", o_tvalid); end
    ready_mode = 1;
    clear_q();
    send_pkt(32'h4000_0000, 8, -1);
    add_exp(32'h4000_0000, 8);
    wait_out(8, "reset_new_pkt");
    checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL mrst_count: got %0d want %0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL mrst_word[%0d]: got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_soak();
    int nerr = 0;
    int k = 0;
    do_reset();
    ready_mode = 2;
    for (int p = 0; p < 40; p++) begin
      int len;
      int eb;
      len = int'($urandom_range(1, 24));
      eb = -1;
      if (p % 9 == 4 || $urandom_range(0, 19) == 0) eb = int'($urandom_range(0, len - 1));
      if (eb >= 0) nerr++;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          idle_in();
          repeat ($urandom_range(0, 16)) @(negedge clk);
        end
        send_beat(32'h7000_0000 + 32'(k), i == len - 1, i == eb);
        if (eb < 0) begin
          exp_d.push_back(32'h7000_0000 + 32'(k));
          exp_l.push_back(i == len - 1);
        end
        k++;
      end
    end
    idle_in();
    wait_out(exp_d.size(), "soak");
    checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL soak_count: got %0d want %0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL soak_word[%0d]: got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    checks++; if (o_err_drops !== 16'(STATS * nerr)) begin errors++; $display("FAIL soak_err_drops: got %0d want %0d", o_err_drops, STATS * nerr); end
    checks++; if (o_pkts_held !== '0) begin errors++; $display("FAIL soak_held: got %0d want 0", o_pkts_held); end
  endtask

  initial begin
    reset_n = 1'b0;
    clear = 1'b0;
    i_tdata = '0;
    idle_in();
    test_reset();
    test_fill_drain();
    test_error_drop();
    test_oversize();
    test_pkt_cap();
    test_back_to_back();
    test_clear_reset();
    test_soak();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
